ram_port_arbiter: RTL and testbench

//   Shares the single-port RAM (registered read, 1-cycle latency) among NUM_REQ

---
 rtl/ram_port_arbiter_if.sv | 30 +++
 rtl/ram_port_arbiter.sv | 99 +++++++++
 tb/tb_ram_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side bus of ram_port_arbiter, flattened per requester.
// slave = arbiter view; master = the environment driving requests and the RAM q.
interface ram_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         ram_addr;
    logic                      ram_we;
    logic [DATA_W-1:0]         ram_wdata;
    logic [DATA_W-1:0]         ram_q;

    modport slave (
        input  req, lock, req_we, req_addr, req_wdata, ram_q,
        output gnt, rvalid, rdata, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output req, lock, req_we, req_addr, req_wdata, ram_q,
        input  gnt, rvalid, rdata, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one registered-read RAM port, with bounded burst lock.
// Define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module ram_port_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               rst,
    ram_port_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_MAX - 1);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               owner_vld_q, owner_vld_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

    logic               lock_hit;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W:0]     cand;
    logic [NUM_REQ-1:0] gnt_oh;

    // A locked owner below its limit wins outright; otherwise search circularly
    // from rr_ptr (held at 0 in fixed-priority builds, giving lowest-index-wins).
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        lock_hit = rst && owner_vld_q && bus.req[owner_q] && bus.lock[owner_q]
                   && (hold_cnt_q < HOLD_LIM);
        if (lock_hit) begin
            gnt_vld = 1'b1;
            gnt_idx = owner_q;
        end else if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
                if (cand >= NUM_REQ_W) begin
                    cand = cand - NUM_REQ_W;
                end
                if (!gnt_vld && bus.req[cand[IDX_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand[IDX_W-1:0];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign gnt_oh[gi] = gnt_vld && (gnt_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        rr_ptr_d = rr_ptr_q;
`ifdef ARB_FIXED_PRIO_EN
        rr_ptr_d = '0;
`else
        if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
        end
`endif
        owner_d     = gnt_idx;
        owner_vld_d = gnt_vld;
        hold_cnt_d  = lock_hit ? hold_cnt_q + CNT_W'(1) : '0;
        rvalid_d    = gnt_oh & ~bus.req_we;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            hold_cnt_q  <= '0;
            rvalid_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            hold_cnt_q  <= hold_cnt_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign bus.gnt       = gnt_oh;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = bus.ram_q;
    assign bus.ram_we    = gnt_vld && bus.req_we[gnt_idx];
    assign bus.ram_addr  = gnt_vld ? bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W] : '0;
    assign bus.ram_wdata = gnt_vld ? bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a registered-read RAM model
// and a per-cycle scoreboard of expected rvalid/rdata.
module tb_ram_port_arbiter;
    localparam int NUM_REQ  = 3;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 8;
    localparam int HOLD_MAX = 4;

    typedef struct packed {
        logic [NUM_REQ-1:0] rv;
        logic [DATA_W-1:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [DATA_W-1:0] mem     [64];
    logic [DATA_W-1:0] ref_mem [64];

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_q <= mem[bus.ram_addr];
    end

    logic [NUM_REQ-1:0] req_v, lock_v, we_v;
    logic [ADDR_W-1:0]  addr_v  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_v [NUM_REQ];
    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic apply();
        bus.req  = req_v;
        bus.lock = lock_v;
        bus.req_we = we_v;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_addr[i*ADDR_W +: ADDR_W]  = addr_v[i];
            bus.req_wdata[i*DATA_W +: DATA_W] = wdata_v[i];
        end
    endtask

    // Expected read return for a bench-predicted grant; writes update the shadow memory.
    task automatic push_exp(input logic [NUM_REQ-1:0] g);
        exp_t x;
        x.rv = '0;
        x.data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g[i]) begin
                if (we_v[i]) ref_mem[addr_v[i]] = wdata_v[i];
                else begin
                    x.rv = g;
                    x.data = ref_mem[addr_v[i]];
                end
            end
        end
        sb.push_back(x);
    endtask

    task automatic clear_inputs();
        req_v = '0; lock_v = '0; we_v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_v[i] = '0;
            wdata_v[i] = '0;
        end
        apply();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        req_v = 3'b111; we_v = 3'b111;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_v[i] = 6'(i + 20);
            wdata_v[i] = 8'(8'hE0 + i);
        end
        apply();
        #1;
        n_tests++;
        if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
        n_tests++;
        if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.ram_we); end
        n_tests++;
        if (bus.ram_addr !== 6'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.ram_addr); end
        n_tests++;
        if (bus.ram_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", bus.ram_wdata); end
        @(posedge clk); #1;
        n_tests++;
        if (bus.rvalid !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 000", bus.rvalid); end
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        #1;
        n_tests++;
        if (bus.gnt !== 3'b000 || bus.ram_we !== 1'b0 || bus.ram_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL idle_bus: gnt=%b we=%b addr=%0d want 000/0/0", bus.gnt, bus.ram_we, bus.ram_addr);
        end
        $display("[TB] reset: gnt=%b rvalid=%b", bus.gnt, bus.rvalid);
    endtask

    task automatic test_single_read();
        logic [NUM_REQ-1:0] exp_g;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            clear_inputs();
            if (c == 0) begin req_v = 3'b001; addr_v[0] = 6'd5; end
            apply();
            exp_g = (c == 0) ? 3'b001 : 3'b000;
            #1;
            n_tests++;
            if (bus.gnt !== exp_g || (c == 0 && bus.ram_addr !== 6'd5)) begin
                n_fail++;
                $display("FAIL single_gnt c%0d: gnt=%b addr=%0d want %b/5", c, bus.gnt, bus.ram_addr, exp_g);
            end
            push_exp(exp_g);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus.rvalid !== e.rv || (e.rv != '0 && bus.rdata !== e.data)) begin
                n_fail++;
                $display("FAIL single_rd c%0d: rvalid=%b rdata=%h want %b/%h", c, bus.rvalid, bus.rdata, e.rv, e.data);
            end
            $display("[TB] single c%0d: gnt=%b rvalid=%b rdata=%h", c, exp_g, bus.rvalid, bus.rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_g;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            clear_inputs();
            if (c < 9) begin
                req_v = 3'b111;
                for (int i = 0; i < NUM_REQ; i++) addr_v[i] = 6'(i + 1);
            end
            apply();
            exp_g = (c < 9) ? 3'(3'b001 << (c % 3)) : 3'b000;
            #1;
            n_tests++;
            if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b want %b", c, bus.gnt, exp_g); end
            push_exp(exp_g);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus.rvalid !== e.rv || (e.rv != '0 && bus.rdata !== e.data)) begin
                n_fail++;
                $display("FAIL rr_rd c%0d: rvalid=%b rdata=%h want %b/%h", c, bus.rvalid, bus.rdata, e.rv, e.data);
            end
            $display("[TB] rr c%0d: gnt=%b rvalid=%b rdata=%h", c, exp_g, bus.rvalid, bus.rdata);
        end
    endtask

    task automatic test_write_read();
        logic [NUM_REQ-1:0] exp_g;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clear_inputs();
            if (c == 0) begin req_v = 3'b010; we_v = 3'b010; addr_v[1] = 6'd10; wdata_v[1] = 8'hA5; end
            if (c == 1) begin req_v = 3'b100; addr_v[2] = 6'd10; end
            apply();
            exp_g = req_v;
            #1;
            n_tests++;
            if (bus.gnt !== exp_g || bus.ram_we !== (c == 0)) begin
                n_fail++;
                $display("FAIL wr_gnt c%0d: gnt=%b we=%b want %b/%b", c, bus.gnt, bus.ram_we, exp_g, c == 0);
            end
            if (c == 0) begin
                n_tests++;
                if (bus.ram_addr !== 6'd10 || bus.ram_wdata !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL wr_bus: addr=%0d wdata=%h want 10/a5", bus.ram_addr, bus.ram_wdata);
                end
            end
            push_exp(exp_g);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus.rvalid !== e.rv || (e.rv != '0 && bus.rdata !== e.data)) begin
                n_fail++;
                $display("FAIL wr_rd c%0d: rvalid=%b rdata=%h want %b/%h", c, bus.rvalid, bus.rdata, e.rv, e.data);
            end
            $display("[TB] wr c%0d: gnt=%b we=%b rvalid=%b rdata=%h", c, exp_g, we_v != 0, bus.rvalid, bus.rdata);
        end
    endtask

`ifndef ARB_FIXED_PRIO_EN
    // Phase 0: req0 locked against req1 -> 4 grants then 1; phase 1: req0 alone keeps regranting.
    task automatic test_lock();
        logic [NUM_REQ-1:0] exp_g;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            clear_inputs();
            addr_v[0] = 6'd5; addr_v[1] = 6'd7;
            if (c < 10)      begin req_v = 3'b011; lock_v = 3'b001; end
            else if (c < 16) begin req_v = 3'b001; lock_v = 3'b001; end
            apply();
            if (c < 10)      exp_g = (c % 5 == 4) ? 3'b010 : 3'b001;
            else if (c < 16) exp_g = 3'b001;
            else             exp_g = 3'b000;
            #1;
            n_tests++;
            if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL lock_gnt c%0d: got %b want %b", c, bus.gnt, exp_g); end
            push_exp(exp_g);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus.rvalid !== e.rv || (e.rv != '0 && bus.rdata !== e.data)) begin
                n_fail++;
                $display("FAIL lock_rd c%0d: rvalid=%b rdata=%h want %b/%h", c, bus.rvalid, bus.rdata, e.rv, e.data);
            end
            $display("[TB] lock c%0d: gnt=%b rvalid=%b", c, exp_g, bus.rvalid);
        end
    endtask

    task automatic test_reset_midstream();
        logic [NUM_REQ-1:0] exp_g;
        logic [NUM_REQ-1:0] seq [8];
        seq = '{3'b010, 3'b100, 3'b010, 3'b000, 3'b010, 3'b100, 3'b010, 3'b000};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            clear_inputs();
            rst = (c == 3) ? 1'b0 : 1'b1;
            if (c < 7) begin req_v = 3'b110; addr_v[1] = 6'd11; addr_v[2] = 6'd12; end
            apply();
            exp_g = seq[c];
            #1;
            n_tests++;
            if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL mid_gnt c%0d: got %b want %b", c, bus.gnt, exp_g); end
            if (c == 3) push_exp(3'b000);
            else push_exp(exp_g);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus.rvalid !== e.rv || (e.rv != '0 && bus.rdata !== e.data)) begin
                n_fail++;
                $display("FAIL mid_rd c%0d: rvalid=%b rdata=%h want %b/%h", c, bus.rvalid, bus.rdata, e.rv, e.data);
            end
            $display("[TB] mid c%0d rst=%b: gnt=%b rvalid=%b", c, rst, exp_g, bus.rvalid);
        end
        rst = 1'b1;
    endtask
`else
    task automatic test_fixed_prio();
        logic [NUM_REQ-1:0] exp_g;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            clear_inputs();
            if (c < 6) begin req_v = 3'b011; addr_v[0] = 6'd5; addr_v[1] = 6'd6; end
            apply();
            exp_g = (c < 6) ? 3'b001 : 3'b000;
            #1;
            n_tests++;
            if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL fixed_gnt c%0d: got %b want %b", c, bus.gnt, exp_g); end
            push_exp(exp_g);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus.rvalid !== e.rv || (e.rv != '0 && bus.rdata !== e.data)) begin
                n_fail++;
                $display("FAIL fixed_rd c%0d: rvalid=%b rdata=%h want %b/%h", c, bus.rvalid, bus.rdata, e.rv, e.data);
            end
            $display("[TB] fixed c%0d: gnt=%b rvalid=%b", c, exp_g, bus.rvalid);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'(i * 7 + 1);
            ref_mem[i] = 8'(i * 7 + 1);
        end
        mem[5] = 8'h3C;
        ref_mem[5] = 8'h3C;
        clear_inputs();
        test_reset();
        test_single_read();
        test_write_read();
`ifndef ARB_FIXED_PRIO_EN
        test_round_robin();
        test_lock();
        test_reset_midstream();
`else
        test_fixed_prio();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
